// File: rtl/mem_block_copy_master.sv
// Avalon-MM block copy engine: moves a run of words inside one on-chip RAM,
// one read then one write per word, ascending, with registered bus outputs.
module mem_block_copy_master #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       words_done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  // state   | meaning
  // IDLE    | waiting for start
  // RD      | read request on the bus
  // RD_WAIT | read accepted, waiting READ_LATENCY cycles for readdata
  // WR      | write request on the bus
  // DONE    | one-cycle completion pulse
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [2:0]      LAT_ONE  = 3'd1;
  localparam logic [2:0]      LAT_INIT = 3'(READ_LATENCY - 1);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]     len_q, len_d, idx_q, idx_d, wcnt_q, wcnt_d;
  logic [2:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d, wr_q, wr_d, cs_q, cs_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [ADDR_W:0]     idx_inc;

  assign idx_inc = idx_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    lat_d   = lat_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wcnt_d = '0;
          if (len != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = len;
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        if (!avm_waitrequest) begin
          lat_d   = LAT_INIT;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == '0) begin
          wdata_d = avm_readdata;
          state_d = S_WR;
        end else begin
          lat_d = lat_q - LAT_ONE;
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          idx_d   = idx_inc;
          wcnt_d  = wcnt_q + CNT_ONE;
          state_d = (idx_inc == len_q) ? S_DONE : S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they are registered
    // yet line up with the state they belong to.
    rd_d   = (state_d == S_RD);
    wr_d   = (state_d == S_WR);
    cs_d   = rd_d | wr_d;
    be_d   = wr_d ? '1 : '0;
    busy_d = (state_d == S_RD) || (state_d == S_RD_WAIT) || (state_d == S_WR);
    done_d = (state_d == S_DONE);
    if (rd_d)
      addr_d = src_d + idx_d[ADDR_W-1:0];
    else if (wr_d)
      addr_d = dst_d + idx_d[ADDR_W-1:0];
    else
      addr_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      lat_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      be_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      lat_q   <= lat_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign words_done     = wcnt_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_mem_block_copy_master.sv
// Directed bench for mem_block_copy_master: RAM model with READ_LATENCY pipeline,
// expected read/write streams from a sequential copy model, compared in order.
module tb_mem_block_copy_master;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW:0]   words_done;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_read, avm_write;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic          avm_waitrequest;

  always #5 clk = ~clk;

  mem_block_copy_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .words_done(words_done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  // RAM model; idle readdata is poisoned so a mistimed capture shows up
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  assign avm_readdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    for (int i = RL-1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (avm_chipselect && avm_read && !avm_waitrequest) ? mem[avm_address] : 32'h5A5A_5A5A;
  end

  logic stall_en;
  initial begin
    int unsigned burst;
    burst = 0;
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!stall_en) avm_waitrequest = 1'b0;
      else if (burst > 0) begin avm_waitrequest = 1'b1; burst--; end
      else if (avm_waitrequest) avm_waitrequest = 1'b0;
      else begin
        burst = $urandom_range(0, 5);
        if (burst > 0) begin avm_waitrequest = 1'b1; burst--; end
      end
    end
  end

  // Bus monitor: records accepted transfers and protocol violations
  logic [AW-1:0] obs_rd[$], obs_wa[$];
  logic [DW-1:0] obs_wd[$];
  int done_cnt = 0, busy_cnt = 0, viol_cnt = 0;
  logic prev_stall = 1'b0;
  logic [AW+DW+1:0] prev_bus = '0;
  always @(negedge clk) begin
    if (avm_read && !avm_waitrequest) obs_rd.push_back(avm_address);
    if (avm_write && !avm_waitrequest) begin
      obs_wa.push_back(avm_address);
      obs_wd.push_back(avm_writedata);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (avm_read && avm_write) viol_cnt++;
    if ((avm_read || avm_write) !== avm_chipselect) viol_cnt++;
    if (avm_byteenable !== (avm_write ? 4'hF : 4'h0)) viol_cnt++;
    if (prev_stall && ({avm_address, avm_read, avm_write, avm_writedata} !== prev_bus)) viol_cnt++;
    prev_stall = (avm_read || avm_write) && avm_waitrequest && !reset;
    prev_bus   = {avm_address, avm_read, avm_write, avm_writedata};
  end

  // Expected streams and checking
  logic [AW-1:0] exp_rd[$], exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [DW-1:0] sh [0:(1<<AW)-1];
  int rp = 0, wp = 0;
  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_addr = a; bd_data = v; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n_rd, input int n_wr);
    logic [AW-1:0] sa, da;
    for (int i = 0; i < n_rd; i++) begin
      sa = s + AW'(i); da = d + AW'(i);
      exp_rd.push_back(sa);
      sh[sa] = mem[sa];
      sh[da] = mem[da];
    end
    for (int i = 0; i < n_wr; i++) begin
      sa = s + AW'(i); da = d + AW'(i);
      sh[da] = sh[sa];
      exp_wa.push_back(da);
      exp_wd.push_back(sh[da]);
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_nrd"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
    check({tag, "_nwr"}, 32'(obs_wa.size()), 32'(exp_wa.size()));
    for (int i = rp; i < exp_rd.size(); i++)
      if (i < obs_rd.size()) check({tag, "_rd_addr"}, 32'(obs_rd[i]), 32'(exp_rd[i]));
    for (int i = wp; i < exp_wa.size(); i++)
      if (i < obs_wa.size()) begin
        check({tag, "_wr_addr"}, 32'(obs_wa[i]), 32'(exp_wa[i]));
        check({tag, "_wr_data"}, obs_wd[i], exp_wd[i]);
      end
    rp = exp_rd.size();
    wp = exp_wa.size();
  endtask

  // start is sampled in cycle 0; returns the cycle in which done is seen
  task automatic do_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                         input int poke_cyc, output int done_cyc);
    int cyc;
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    cyc = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == poke_cyc) begin
        start = 1'b1; src_addr = ~s; dst_addr = d + 13'd100; len = 14'd7;
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int dc, d0, b0, r0, w0;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 32'({busy, done, avm_chipselect, avm_read, avm_write, avm_byteenable}), 32'd0);
    check("rst_words_done", 32'(words_done), 32'd0);
    check("rst_addr_wdata", 32'(avm_address) | avm_writedata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic copy
    for (int i = 0; i < 4; i++) poke(13'h010 + 13'(i), 32'hA0 + 32'(i));
    model(13'h010, 13'h100, 4, 4);
    d0 = done_cnt;
    do_copy(13'h010, 13'h100, 14'd4, -1, dc);
    check("basic_done_cycle", 32'(dc), 32'd13);
    check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("basic_words_done", 32'(words_done), 32'd4);
    verify("basic");
    for (int i = 0; i < 4; i++) check("basic_mem", mem[13'h100 + 13'(i)], 32'hA0 + 32'(i));

    // zero length
    d0 = done_cnt; b0 = busy_cnt; r0 = obs_rd.size(); w0 = obs_wa.size();
    do_copy(13'h005, 13'h006, 14'd0, -1, dc);
    check("zero_done_cycle", 32'(dc), 32'd1);
    check("zero_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("zero_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    check("zero_bus_activity", 32'(obs_rd.size() - r0 + obs_wa.size() - w0), 32'd0);
    check("zero_words_done", 32'(words_done), 32'd0);

    // wrap and stall
    poke(13'h1FFE, 32'h1111_0001);
    poke(13'h1FFF, 32'h2222_0002);
    poke(13'h0000, 32'h3333_0003);
    model(13'h1FFE, 13'h0005, 3, 3);
    stall_en = 1'b1;
    do_copy(13'h1FFE, 13'h0005, 14'd3, -1, dc);
    stall_en = 1'b0;
    check("wrap_no_timeout", 32'(dc > 0), 32'd1);
    check("wrap_words_done", 32'(words_done), 32'd3);
    verify("wrap");
    check("wrap_mem_7", mem[13'h0007], 32'h3333_0003);

    // overlapping ascending copy
    for (int i = 0; i < 4; i++) poke(13'(i), 32'(i + 1));
    model(13'h0, 13'h1, 3, 3);
    do_copy(13'h0, 13'h1, 14'd3, -1, dc);
    check("ovl_done_cycle", 32'(dc), 32'd10);
    verify("ovl");
    for (int i = 0; i < 4; i++) check("ovl_mem", mem[13'(i)], 32'd1);

    // reset during the third word's RD_WAIT (cycle 8)
    for (int i = 0; i < 3; i++) poke(13'h200 + 13'(i), 32'hC0 + 32'(i));
    poke(13'h302, 32'h0);
    model(13'h200, 13'h300, 3, 2);
    d0 = done_cnt;
    start = 1'b1; src_addr = 13'h200; dst_addr = 13'h300; len = 14'd5;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("rst_mid_in_rdwait", 32'({busy, avm_read, avm_write}), 32'b100);
    reset = 1'b1;
    #1;
    check("rst_mid_ctl", 32'({busy, done, avm_chipselect, avm_read, avm_write, avm_byteenable}), 32'd0);
    check("rst_mid_words_done", 32'(words_done), 32'd0);
    check("rst_mid_addr_wdata", 32'(avm_address) | avm_writedata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    verify("rst_mid");
    check("rst_mid_mem_unwritten", mem[13'h302], 32'h0);
    model(13'h200, 13'h400, 2, 2);
    do_copy(13'h200, 13'h400, 14'd2, -1, dc);
    check("after_rst_done_cycle", 32'(dc), 32'd7);
    check("after_rst_words_done", 32'(words_done), 32'd2);
    verify("after_rst");

    // start while busy is ignored
    for (int i = 0; i < 4; i++) poke(13'h600 + 13'(i), 32'hE0 + 32'(i));
    model(13'h600, 13'h700, 4, 4);
    d0 = done_cnt;
    do_copy(13'h600, 13'h700, 14'd4, 5, dc);
    check("busy_start_done_cycle", 32'(dc), 32'd13);
    check("busy_start_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_start_words_done", 32'(words_done), 32'd4);
    verify("busy_start");

    check("protocol_violations", 32'(viol_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
